// File: rtl/rx_mac_frontend.sv
// Ethernet RX front-end: MII/GMII byte assembly, preamble/SFD check,
// FCS strip and check, frame flags, AXI-stream out and frame statistics.
module rx_mac_frontend #(
  parameter string MEDIA_TYPES = "1000Base",
  parameter int    MIN_FRAME   = 64,
  parameter int    MAX_FRAME   = 1518,
  parameter int    CNT_W       = 32
) (
  input  logic             rx_clk,
  input  logic             rst,
  input  logic [7:0]       rxd,
  input  logic             rx_en,
  input  logic             rx_er,
  output logic             m_axis_aclk,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic [15:0]      frame_len,
  output logic [CNT_W-1:0] frame_good_cnt,
  output logic [CNT_W-1:0] frame_bad_cnt
);

  localparam bit MII = (MEDIA_TYPES == "100Base");

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;
  localparam logic [31:0] POLY     = 32'hEDB8_8320;
  localparam logic [15:0] MIN_L    = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_L    = 16'(MAX_FRAME);
  localparam logic [15:0] HOLD_N   = 16'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_END,
    S_DROP
  } state_t;

  state_t      state;
  state_t      nxt;
  state_t      pre_nxt;
  logic        armed;
  logic        phase;
  logic [3:0]  lo_nib;
  logic        byte_vld;
  logic [7:0]  byte_dat;
  logic        seen55;
  logic        pre_seen;
  logic        sfd;
  logic        bad;
  logic [31:0] crc;
  logic [15:0] len;
  logic        er_flag;
  logic [7:0]  dl [4];
  logic [7:0]  hold;

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign m_axis_aclk = rx_clk;

  // Byte strobe: every enabled cycle on GMII, every 2nd nibble on MII
  always_comb begin
    byte_vld = rx_en;
    byte_dat = rxd;
    if (MII) begin
      byte_vld = rx_en && phase;
      byte_dat = {rxd[3:0], lo_nib};
    end
  end

  // Nibble phase; armed blocks a frame already in flight at reset
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      armed  <= 1'b0;
      phase  <= 1'b0;
      lo_nib <= 4'd0;
    end else begin
      if (!rx_en)
        armed <= 1'b1;
      if (!rx_en || state == S_END || !armed) begin
        phase <= 1'b0;
      end else if (MII) begin
        if (!phase)
          lo_nib <= rxd[3:0];
        phase <= !phase;
      end
    end
  end

  // Preamble byte classification
  always_comb begin
    pre_seen = (state == S_PRE) && seen55;
    pre_nxt  = S_DROP;
    if (byte_dat == 8'h55)
      pre_nxt = S_PRE;
    else if (byte_dat == 8'hD5 && pre_seen)
      pre_nxt = S_DATA;
  end

  // Remember whether a 0x55 has been seen in this preamble
  always_ff @(posedge rx_clk) begin
    if (rst)
      seen55 <= 1'b0;
    else
      seen55 <= pre_seen || (byte_vld && byte_dat == 8'h55);
  end

  // State register
  always_ff @(posedge rx_clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (armed && rx_en)
          nxt = byte_vld ? pre_nxt : S_PRE;
      end
      S_PRE: begin
        if (!rx_en)
          nxt = S_IDLE;
        else if (byte_vld)
          nxt = pre_nxt;
      end
      S_DATA: begin
        if (!rx_en)
          nxt = S_END;
      end
      S_END:   nxt = S_IDLE;
      S_DROP: begin
        if (!rx_en)
          nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign sfd = (state != S_DATA) && (nxt == S_DATA);

  // phase still set at the drop means a dangling nibble
  assign bad = (crc != RESIDUE) || (len < MIN_L) ||
               (len > MAX_L) || er_flag || rx_er || phase;

  // CRC/length, FCS delay line, stream output and statistics
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      m_axis_tdata   <= 8'd0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= 1'b0;
      frame_len      <= 16'd0;
      frame_good_cnt <= '0;
      frame_bad_cnt  <= '0;
      crc            <= CRC_INIT;
      len            <= 16'd0;
      er_flag        <= 1'b0;
      hold           <= 8'd0;
      for (int i = 0; i < 4; i++)
        dl[i] <= 8'd0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      if (sfd) begin
        crc     <= CRC_INIT;
        len     <= 16'd0;
        er_flag <= 1'b0;
      end
      if (state == S_DATA) begin
        if (rx_er)
          er_flag <= 1'b1;
        if (byte_vld) begin
          crc <= crc_upd(crc, byte_dat);
          if (len != 16'hFFFF)
            len <= len + 16'd1;
          dl[0] <= byte_dat;
          dl[1] <= dl[0];
          dl[2] <= dl[1];
          dl[3] <= dl[2];
          hold  <= dl[3];
          if (len >= HOLD_N) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hold;
          end
        end else if (!rx_en) begin
          frame_len <= len;
          if (len >= HOLD_N) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hold;
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= bad;
          end
          if (bad || len < HOLD_N)
            frame_bad_cnt <= frame_bad_cnt + CNT_W'(1);
          else
            frame_good_cnt <= frame_good_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
